// File: rtl/radio_pkg.sv
// radio_pkg: helpers shared by the demapper chain (mapper, gray2bin, symbol_byte_packer).
//   bits_per_sym(order)      : number of bits carried by one symbol of a 2^k constellation
//   order_ok(order)          : constellation size is a power of two and at least 2
//   width_ok(order, width)   : a word of 'width' bits can hold at least one whole symbol
package radio_pkg;

  function automatic int unsigned bits_per_sym(input int unsigned order);
    return $clog2(order);
  endfunction

  function automatic bit order_ok(input int unsigned order);
    return (order >= 2) && ((order & (order - 1)) == 0);
  endfunction

  function automatic bit width_ok(input int unsigned order, input int unsigned width);
    return width >= bits_per_sym(order);
  endfunction

endpackage

// File: rtl/symbol_byte_packer_if.sv
// symbol_byte_packer_if: symbol input stream plus packed-word output stream.
//   binary_code/dv/flush : demapped symbol bits, valid strobe, end-of-frame marker
//   out_data/out_last/out_valid/out_ready : packed word stream toward the byte sink
//   overflow             : sticky word-loss flag
// master = symbol source / word sink side, slave = packer side.
interface symbol_byte_packer_if #(
  parameter int unsigned BITS_PER_SYM = 4,
  parameter int unsigned OUT_WIDTH    = 8
);
  logic [BITS_PER_SYM-1:0] binary_code;
  logic                    dv;
  logic                    flush;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overflow;

  modport master (
    output binary_code, dv, flush, out_ready,
    input  out_data, out_last, out_valid, overflow
  );

  modport slave (
    input  binary_code, dv, flush, out_ready,
    output out_data, out_last, out_valid, overflow
  );
endinterface

// File: rtl/packer_fifo.sv
// packer_fifo: DEPTH x WIDTH synchronous FIFO with two ordered write ports and one read port.
//   wr0_en/wr0_data : first write of the cycle
//   wr1_en/wr1_data : second write, only honoured together with wr0_en, lands behind wr0
//   rd_en           : pop head (caller must not pop when empty)
//   rd_data         : current head entry
//   empty / free    : occupancy status, free = DEPTH - count
module packer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr0_en,
  input  logic [WIDTH-1:0]             wr0_data,
  input  logic                         wr1_en,
  input  logic [WIDTH-1:0]             wr1_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   free
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, wr_ptr1;
  logic [CW-1:0]    count;
  logic             wr1_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr1 = inc(wr_ptr);
    wr1_ok  = wr0_en & wr1_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (rd_en) rd_ptr <= inc(rd_ptr);
      if (wr0_en) begin
        mem[wr_ptr] <= wr0_data;
        wr_ptr      <= wr1_ok ? inc(wr_ptr1) : wr_ptr1;
      end
      if (wr1_ok) mem[wr_ptr1] <= wr1_data;
      count <= count - CW'(rd_en) + CW'(wr0_en) + CW'(wr1_ok);
    end
  end

  always_comb begin
    rd_data = mem[rd_ptr];
    empty   = (count == '0);
    free    = CW'(DEPTH) - count;
  end
endmodule

// File: rtl/symbol_byte_packer.sv
// symbol_byte_packer: packs BITS_PER_SYM-bit symbols MSB-first into OUT_WIDTH-bit words.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : symbol_byte_packer_if.slave (binary_code/dv/flush in, out_* word stream out,
//              overflow sticky flag out)
// Words are buffered in packer_fifo because the symbol side cannot be stalled; words that do not
// fit are dropped in order and overflow is latched until reset.
module symbol_byte_packer
  import radio_pkg::*;
#(
  parameter int unsigned MODULATION_ORDER = 16,
  parameter int unsigned OUT_WIDTH        = 8,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  symbol_byte_packer_if.slave      bus
);
  localparam int unsigned B   = bits_per_sym(MODULATION_ORDER);
  localparam int unsigned AW  = OUT_WIDTH + B;
  localparam int unsigned SW  = $clog2(AW) + 1;
  localparam int unsigned FW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AVW = FW + 1;
  localparam logic [SW-1:0] OW = SW'(OUT_WIDTH);
  localparam logic [SW-1:0] BW = SW'(B);

  if (!order_ok(MODULATION_ORDER)) begin : g_bad_order
    $error("MODULATION_ORDER must be a power of two >= 2");
  end
  if (!width_ok(MODULATION_ORDER, OUT_WIDTH)) begin : g_bad_width
    $error("OUT_WIDTH must be >= bits per symbol");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("FIFO_DEPTH must be >= 2");
  end

  // Residual bits are kept right-aligned in acc; only the low cnt bits are meaningful.
  logic [AW-1:0]        acc, acc_nxt, ext, rem;
  logic [SW-1:0]        cnt, cnt_nxt, n, n_rem;
  logic                 full;
  logic [OUT_WIDTH-1:0] full_word, res_word;
  logic                 push0, push1;
  logic [OUT_WIDTH:0]   d0, d1;
  logic                 pop, wr0, wr1, drop, empty, overflow;
  logic [FW-1:0]        free;
  logic [AVW-1:0]       avail;
  logic [OUT_WIDTH:0]   head;

  always_comb begin
    ext = acc;
    n   = cnt;
    if (bus.dv) begin
      ext = (acc << B) | AW'(bus.binary_code);
      n   = cnt + BW;
    end
    full      = (n >= OW);
    n_rem     = full ? n - OW : n;
    full_word = OUT_WIDTH'(ext >> (n - OW));
    rem       = ext & ((AW'(1) << n_rem) - AW'(1));
    // Left-align the residual; the zero fill below it becomes the LSB padding.
    res_word  = OUT_WIDTH'(rem << (OW - n_rem));

    acc_nxt = rem;
    cnt_nxt = n_rem;
    push0   = full;
    d0      = {1'b0, full_word};
    push1   = 1'b0;
    d1      = {1'b1, res_word};

    // The full word (if any) always goes first; the last flag lands on whichever word ends the frame.
    if (bus.flush) begin
      acc_nxt = '0;
      cnt_nxt = '0;
      if (full) begin
        if (n_rem != '0) push1 = 1'b1;
        else             d0[OUT_WIDTH] = 1'b1;
      end else if (n_rem != '0) begin
        push0 = 1'b1;
        d0    = {1'b1, res_word};
      end
    end
  end

  // Space freed by a same-cycle pop is usable by this cycle's pushes.
  always_comb begin
    pop   = bus.out_valid & bus.out_ready;
    avail = AVW'(free) + AVW'(pop);
    wr0   = push0 & (avail != '0);
    wr1   = push1 & (avail > AVW'(1));
    drop  = (push0 & ~wr0) | (push1 & ~wr1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (drop) overflow <= 1'b1;
    end
  end

  packer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0),
    .wr0_data (d0),
    .wr1_en   (wr1),
    .wr1_data (d1),
    .rd_en    (pop),
    .rd_data  (head),
    .empty    (empty),
    .free     (free)
  );

  always_comb begin
    bus.out_valid = ~empty;
    bus.out_data  = head[OUT_WIDTH-1:0];
    bus.out_last  = head[OUT_WIDTH];
    bus.overflow  = overflow;
  end
endmodule
